spi_slave: RTL and testbench

//  Bit-bang SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first. It consumes the
//  spi_cs_n/spi_clock/spi_mosi wires produced by spi_master and drives
//  spi_miso back. It is the far end of the SPI link.

---
 rtl/spi_slave_if.sv | 25 ++
 rtl/spi_slave.sv | 124 ++++++++++++
 tb/tb_spi_slave.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Word-side and SPI-wire signals of the SPI slave, grouped so the slave and its
// surroundings connect through one port.
interface spi_slave_if #(
   parameter int W = 8
);
   logic [W-1:0] in;
   logic         get;
   logic         empty;
   logic [W-1:0] out;
   logic         put;
   logic         spi_cs_n;
   logic         spi_clock;
   logic         spi_mosi;
   logic         spi_miso;

   modport slave (
      input  in, empty, spi_cs_n, spi_clock, spi_mosi,
      output get, out, put, spi_miso
   );

   modport master (
      output in, empty, spi_cs_n, spi_clock, spi_mosi,
      input  get, out, put, spi_miso
   );
endinterface

// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI slave oversampled by the system clock. Received words
// are published on out/put and transmit words are pulled from an upstream source.
module spi_slave #(
   parameter int           W    = 8,
   parameter logic [W-1:0] FILL = {W{1'b1}}
) (
   input logic        clock,
   input logic        reset_n,
   spi_slave_if.slave bus
);
   localparam int CW = $clog2(W);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        r_state;
   logic          r_csS1, r_csS2, r_csPrev;
   logic          r_sckS1, r_sckS2, r_sckPrev;
   logic          r_mosiS1, r_mosiS2;
   logic [CW-1:0] r_count;
   logic          r_started;
   logic [W-1:0]  r_tx;
   logic [W-2:0]  r_rx;
   logic [W-1:0]  r_out;
   logic          r_get;
   logic          r_put;

   logic          w_csFall, w_csRise, w_sckRise, w_sckFall;
   logic [W-1:0]  w_rxNext;
   logic [W-1:0]  w_loadWord;
   logic          w_loadGet;

   // Two-flop synchronisers plus a third copy that serves as the edge reference.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_csS1    <= 1'b1;
         r_csS2    <= 1'b1;
         r_csPrev  <= 1'b1;
         r_sckS1   <= 1'b0;
         r_sckS2   <= 1'b0;
         r_sckPrev <= 1'b0;
         r_mosiS1  <= 1'b0;
         r_mosiS2  <= 1'b0;
      end else begin
         r_csS1    <= bus.spi_cs_n;
         r_csS2    <= r_csS1;
         r_csPrev  <= r_csS2;
         r_sckS1   <= bus.spi_clock;
         r_sckS2   <= r_sckS1;
         r_sckPrev <= r_sckS2;
         r_mosiS1  <= bus.spi_mosi;
         r_mosiS2  <= r_mosiS1;
      end
   end

   assign w_csFall   = r_csPrev & ~r_csS2;
   assign w_csRise   = ~r_csPrev & r_csS2;
   assign w_sckRise  = ~r_sckPrev & r_sckS2;
   assign w_sckFall  = r_sckPrev & ~r_sckS2;
   assign w_rxNext   = {r_rx, r_mosiS2};
   assign w_loadWord = bus.empty ? FILL : bus.in;
   assign w_loadGet  = ~bus.empty;

   // cs rising edge takes priority over everything, so a coincident sck edge never completes a word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_started <= 1'b0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_out     <= '0;
         r_get     <= 1'b0;
         r_put     <= 1'b0;
      end else begin
         r_get <= 1'b0;
         r_put <= 1'b0;
         if (w_csRise) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_started <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_csFall) begin
                     r_tx      <= w_loadWord;
                     r_get     <= w_loadGet;
                     r_count   <= '0;
                     r_started <= 1'b0;
                     r_state   <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (w_sckRise) begin
                     r_rx      <= w_rxNext[W-2:0];
                     r_started <= 1'b1;
                     if (r_count == CW'(W - 1)) begin
                        r_out   <= w_rxNext;
                        r_put   <= 1'b1;
                        r_count <= '0;
                     end else begin
                        r_count <= r_count + 1'b1;
                     end
                  end else if (w_sckFall) begin
                     // A zero count is a word boundary only once that word has seen a rising edge.
                     if (r_count != '0) begin
                        r_tx <= r_tx << 1;
                     end else if (r_started) begin
                        r_tx      <= w_loadWord;
                        r_get     <= w_loadGet;
                        r_started <= 1'b0;
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.get      = r_get;
   assign bus.put      = r_put;
   assign bus.out      = r_out;
   assign bus.spi_miso = (r_state == SHIFT) ? r_tx[W-1] : 1'b1;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master, a word source that
// follows get, and a monitor that logs put words and get pulses.
module tb_spi_slave;
   localparam int W = 8;
   localparam int H = 8;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   spi_slave_if #(.W(W)) bus ();

   spi_slave #(.W(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   logic [W-1:0] srcWords [0:7];
   int           srcCount = 0;
   int           srcIdx   = 0;

   assign bus.in    = (srcIdx < srcCount && srcIdx < 8) ? srcWords[srcIdx] : '0;
   assign bus.empty = (srcIdx >= srcCount);

   logic [W-1:0] txWords   [0:3];
   logic [W-1:0] misoWords [0:3];
   logic [W-1:0] rxLog     [0:15];
   int           putCount = 0;
   int           getCount = 0;

   int vectorCount = 0;
   int missCount   = 0;

   // Monitor samples on the falling system edge, away from the DUT's active edge.
   always @(negedge clock) begin
      if (bus.put) begin
         if (putCount < 16) rxLog[putCount] = bus.out;
         putCount = putCount + 1;
      end
      if (bus.get) begin
         getCount = getCount + 1;
         srcIdx   = srcIdx + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic loadSource(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input int n);
      srcWords[0] = a;
      srcWords[1] = b;
      srcWords[2] = c;
      srcIdx      = 0;
      srcCount    = n;
      putCount    = 0;
      getCount    = 0;
   endtask

   task automatic sendBit(input logic b, output logic misoBit);
      bus.spi_mosi = b;
      waitClocks(H);
      misoBit = bus.spi_miso;
      bus.spi_clock = 1'b1;
      waitClocks(H);
      bus.spi_clock = 1'b0;
   endtask

   // One cs frame carrying nBits bits of txWords, MSB first; miso is captured per bit.
   task automatic applyStimulus(input int nBits);
      logic m;
      bus.spi_cs_n = 1'b0;
      waitClocks(H);
      for (int k = 0; k < nBits; k++) begin
         sendBit(txWords[k / W][W - 1 - (k % W)], m);
         misoWords[k / W][W - 1 - (k % W)] = m;
      end
      waitClocks(H);
      bus.spi_cs_n = 1'b1;
      waitClocks(H);
   endtask

   initial begin
      logic m;
      bus.spi_cs_n  = 1'b1;
      bus.spi_clock = 1'b0;
      bus.spi_mosi  = 1'b0;
      for (int i = 0; i < 8; i++) srcWords[i] = '0;
      waitClocks(3);
      reset_n = 1'b1;
      waitClocks(2);

      // Reset state, then sck toggling while deselected must be ignored.
      checkOutput("reset_out",  bus.out,      32'h0);
      checkOutput("reset_put",  bus.put,      32'h0);
      checkOutput("reset_get",  bus.get,      32'h0);
      checkOutput("reset_miso", bus.spi_miso, 32'h1);
      for (int i = 0; i < 4; i++) begin
         bus.spi_clock = 1'b1;
         waitClocks(H);
         checkOutput("idle_miso_hi", bus.spi_miso, 32'h1);
         bus.spi_clock = 1'b0;
         waitClocks(H);
         checkOutput("idle_miso_lo", bus.spi_miso, 32'h1);
      end
      checkOutput("idle_puts", putCount, 32'd0);
      checkOutput("idle_gets", getCount, 32'd0);

      // Single word each way.
      loadSource(8'hA5, 8'h00, 8'h00, 1);
      txWords[0] = 8'h3C;
      applyStimulus(W);
      checkOutput("t2_gets",  getCount,     32'd1);
      checkOutput("t2_puts",  putCount,     32'd1);
      checkOutput("t2_rx",    rxLog[0],     32'h3C);
      checkOutput("t2_out",   bus.out,      32'h3C);
      checkOutput("t2_miso",  misoWords[0], 32'hA5);
      checkOutput("t2_idle",  bus.spi_miso, 32'h1);

      // Three back-to-back words in one frame.
      loadSource(8'h11, 8'h22, 8'h33, 3);
      txWords[0] = 8'h48;
      txWords[1] = 8'h65;
      txWords[2] = 8'h6C;
      applyStimulus(3 * W);
      checkOutput("t3_gets",  getCount,     32'd3);
      checkOutput("t3_puts",  putCount,     32'd3);
      checkOutput("t3_rx0",   rxLog[0],     32'h48);
      checkOutput("t3_rx1",   rxLog[1],     32'h65);
      checkOutput("t3_rx2",   rxLog[2],     32'h6C);
      checkOutput("t3_miso0", misoWords[0], 32'h11);
      checkOutput("t3_miso1", misoWords[1], 32'h22);
      checkOutput("t3_miso2", misoWords[2], 32'h33);

      // Aborted frame after 5 bits, then a clean frame.
      loadSource(8'h77, 8'h96, 8'h00, 2);
      txWords[0] = 8'hF0;
      applyStimulus(5);
      checkOutput("t5_puts",  putCount,     32'd0);
      checkOutput("t5_gets",  getCount,     32'd1);
      checkOutput("t5_hold",  bus.out,      32'h6C);
      txWords[0] = 8'hC3;
      applyStimulus(W);
      checkOutput("t5_puts2", putCount,     32'd1);
      checkOutput("t5_rx",    rxLog[0],     32'hC3);
      checkOutput("t5_miso",  misoWords[0], 32'h96);

      // Empty source: FILL goes out and no get is issued.
      loadSource(8'h00, 8'h00, 8'h00, 0);
      txWords[0] = 8'h00;
      applyStimulus(W);
      checkOutput("t4_gets",  getCount,     32'd0);
      checkOutput("t4_puts",  putCount,     32'd1);
      checkOutput("t4_out",   bus.out,      32'h00);
      checkOutput("t4_miso",  misoWords[0], 32'hFF);

      // Reset pulse in the middle of a word.
      loadSource(8'hE7, 8'h00, 8'h00, 1);
      txWords[0] = 8'h81;
      applyStimulus(W);
      checkOutput("t6_pre",   bus.out,      32'h81);
      loadSource(8'h3E, 8'h00, 8'h00, 1);
      bus.spi_cs_n = 1'b0;
      waitClocks(H);
      for (int i = 0; i < 4; i++) sendBit(i[0], m);
      waitClocks(2);
      reset_n = 1'b0;
      #1;
      checkOutput("t6_out",   bus.out,      32'h0);
      checkOutput("t6_put",   bus.put,      32'h0);
      checkOutput("t6_get",   bus.get,      32'h0);
      checkOutput("t6_miso",  bus.spi_miso, 32'h1);
      bus.spi_cs_n  = 1'b1;
      bus.spi_clock = 1'b0;
      waitClocks(3);
      reset_n = 1'b1;
      waitClocks(H);
      loadSource(8'hB4, 8'h00, 8'h00, 1);
      txWords[0] = 8'h5A;
      applyStimulus(W);
      checkOutput("t6_puts",  putCount,     32'd1);
      checkOutput("t6_rx",    rxLog[0],     32'h5A);
      checkOutput("t6_miso2", misoWords[0], 32'hB4);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end
endmodule
